// File: rtl/flip_pkg.sv
// Shared types and helpers for the BRAM rectangle flip sequencer.
package flip_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      CAP_B,
      WR_A,
      WR_B,
      DONE
   } flip_state_t;

   // Cycles spent on one pixel exchange (RD_A through WR_B).
   localparam int SWAP_CYCLES = 5;

   // Linear address of pixel (x, y). Callers truncate to the BRAM width; the low
   // bits equal an ADDR_W+COORD_W-bit computation whenever that sum is <= 32.
   function automatic logic [31:0] flip_addr(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input logic [31:0] stride);
      return y * stride + x;
   endfunction

endpackage

// File: rtl/flip_addr_gen.sv
// Loop counters and A/B pixel address generation for the flip sequencer.
module flip_addr_gen
   import flip_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int COORD_W = 4,
   parameter int STRIDE  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
   input  logic               vflip,
   output logic [ADDR_W-1:0]  addr_a,
   output logic [ADDR_W-1:0]  addr_b,
   output logic               last,
   output logic               empty
);

   logic [COORD_W-1:0] x0_reg, y0_reg, w_reg, h_reg;
   logic               vflip_reg;
   logic [COORD_W-1:0] i_reg, j_reg;
   logic [COORD_W-1:0] i_lim, j_lim;
   logic [31:0]        xa, ya, xb, yb;

   // Evaluated on the live inputs so IDLE can skip straight to DONE.
   assign empty = vflip ? ((h < COORD_W'(2)) || (w == '0))
                        : ((w < COORD_W'(2)) || (h == '0));

   assign i_lim = vflip_reg ? w_reg : (w_reg >> 1);
   assign j_lim = vflip_reg ? (h_reg >> 1) : h_reg;
   assign last  = (i_reg == i_lim - COORD_W'(1)) && (j_reg == j_lim - COORD_W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         x0_reg    <= '0;
         y0_reg    <= '0;
         w_reg     <= '0;
         h_reg     <= '0;
         vflip_reg <= 1'b0;
         i_reg     <= '0;
         j_reg     <= '0;
      end else if (load) begin
         x0_reg    <= x0;
         y0_reg    <= y0;
         w_reg     <= w;
         h_reg     <= h;
         vflip_reg <= vflip;
         i_reg     <= '0;
         j_reg     <= '0;
      end else if (step) begin
         if (i_reg == i_lim - COORD_W'(1)) begin
            i_reg <= '0;
            j_reg <= j_reg + COORD_W'(1);
         end else begin
            i_reg <= i_reg + COORD_W'(1);
         end
      end
   end

   always_comb begin
      xa = 32'(x0_reg) + 32'(i_reg);
      ya = 32'(y0_reg) + 32'(j_reg);
      xb = xa;
      yb = ya;
      if (vflip_reg)
         yb = 32'(y0_reg) + 32'(h_reg) - 32'd1 - 32'(j_reg);
      else
         xb = 32'(x0_reg) + 32'(w_reg) - 32'd1 - 32'(i_reg);
   end

   assign addr_a = ADDR_W'(flip_addr(xa, ya, 32'(STRIDE)));
   assign addr_b = ADDR_W'(flip_addr(xb, yb, 32'(STRIDE)));

endmodule

// File: rtl/bram_flip_sequencer.sv
// Mirrors a rectangle of a BRAM-held image in place, one 5-cycle swap at a time.
// Optional vertical mode (vflip port) is enabled by defining FLIP_VERT_EN.
module bram_flip_sequencer
   import flip_pkg::*;
#(
   parameter int DATA_W  = 4,
   parameter int ADDR_W  = 8,
   parameter int COORD_W = 4,
   parameter int STRIDE  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] y0,
   input  logic [COORD_W-1:0] w,
   input  logic [COORD_W-1:0] h,
`ifdef FLIP_VERT_EN
   input  logic               vflip,
`endif
   output logic               busy,
   output logic               done,
   output logic               bram_en,
   output logic               bram_we,
   output logic [ADDR_W-1:0]  bram_addr,
   output logic [DATA_W-1:0]  bram_wdata,
   input  logic [DATA_W-1:0]  bram_rdata
);

   flip_state_t         state_reg, state_next;
   logic [DATA_W-1:0]   pix_a_reg, pix_b_reg;
   logic [ADDR_W-1:0]   addr_a, addr_b;
   logic                last, empty, accept, mode_v;

`ifdef FLIP_VERT_EN
   assign mode_v = vflip;
`else
   assign mode_v = 1'b0;
`endif

   assign accept = (state_reg == IDLE) && start;

   flip_addr_gen #(
      .ADDR_W (ADDR_W),
      .COORD_W(COORD_W),
      .STRIDE (STRIDE)
   ) u_addr_gen (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .step  (state_reg == WR_B),
      .x0    (x0),
      .y0    (y0),
      .w     (w),
      .h     (h),
      .vflip (mode_v),
      .addr_a(addr_a),
      .addr_b(addr_b),
      .last  (last),
      .empty (empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         pix_a_reg <= '0;
         pix_b_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == RD_B)
            pix_a_reg <= bram_rdata;
         if (state_reg == CAP_B)
            pix_b_reg <= bram_rdata;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = empty ? DONE : RD_A;
         RD_A:    state_next = RD_B;
         RD_B:    state_next = CAP_B;
         CAP_B:   state_next = WR_A;
         WR_A:    state_next = WR_B;
         WR_B:    state_next = last ? DONE : RD_A;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // BRAM strobes are gated by reset so an abort cannot land one last write.
   always_comb begin
      bram_en    = 1'b0;
      bram_we    = 1'b0;
      bram_addr  = '0;
      bram_wdata = '0;
      if (!reset) begin
         case (state_reg)
            RD_A: begin
               bram_en   = 1'b1;
               bram_addr = addr_a;
            end
            RD_B: begin
               bram_en   = 1'b1;
               bram_addr = addr_b;
            end
            WR_A: begin
               bram_en    = 1'b1;
               bram_we    = 1'b1;
               bram_addr  = addr_a;
               bram_wdata = pix_b_reg;
            end
            WR_B: begin
               bram_en    = 1'b1;
               bram_we    = 1'b1;
               bram_addr  = addr_b;
               bram_wdata = pix_a_reg;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);

endmodule

// File: tb/tb_bram_flip_sequencer.sv
// Bench for bram_flip_sequencer: BRAM model, swap-list reference model and cycle-level compare.
`timescale 1ns/1ps
module tb_bram_flip_sequencer;

`ifdef FLIP_VERT_EN
   localparam int DW = 8;
`else
   localparam int DW = 4;
`endif
   localparam int AW = 8;
   localparam int CW = 4;
   localparam int ST = 16;
   localparam int NW = 256;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] x0 = '0, y0 = '0, w = '0, h = '0;
`ifdef FLIP_VERT_EN
   logic          vflip = 1'b0;
`endif
   logic          busy, done, bram_en, bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wdata;
   logic [DW-1:0] bram_rdata;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   bram_flip_sequencer #(.DATA_W(DW), .ADDR_W(AW), .COORD_W(CW), .STRIDE(ST)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .x0        (x0),
      .y0        (y0),
      .w         (w),
      .h         (h),
`ifdef FLIP_VERT_EN
      .vflip     (vflip),
`endif
      .busy      (busy),
      .done      (done),
      .bram_en   (bram_en),
      .bram_we   (bram_we),
      .bram_addr (bram_addr),
      .bram_wdata(bram_wdata),
      .bram_rdata(bram_rdata)
   );

   // BRAM model with a preload path and write counters
   logic [DW-1:0] mem [NW];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;
   int            wr_cnt = 0;
   int            centre_wr = 0;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (bram_en) begin
         if (bram_we) begin
            mem[bram_addr] <= bram_wdata;
            wr_cnt <= wr_cnt + 1;
            if (bram_addr == 8'd20 || bram_addr == 8'd36)
               centre_wr <= centre_wr + 1;
         end else begin
            bram_rdata <= mem[bram_addr];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
   endtask

   // Reference data handed to the compare process when a start is accepted
   int            cfg_s = 0;
   int            cfg_pa [64];
   int            cfg_pb [64];
   logic [DW-1:0] img_start [NW];
   logic [DW-1:0] golden [NW];

   // Compare process: each accepted op is S swaps of 5 cycles, then a done cycle.
   initial begin : compare
      int k = 0;
      int s = 0;
      int p, n, t;
      int pa [64];
      int pb [64];
      logic [DW-1:0] cur [NW];
      logic st, rs;
      forever begin
         @(posedge clk);
         st = start;
         rs = reset;
         #1;
         if (rs) k = 0;
         else if (k == 0) begin
            if (st) begin
               k = 1; s = cfg_s; pa = cfg_pa; pb = cfg_pb; cur = img_start;
            end
         end else if (k == 5 * s + 1) k = 0;
         else k++;

         check("busy", busy, 32'(k != 0));
         check("done", done, 32'(k != 0 && k == 5 * s + 1));
         if (k == 0 || k == 5 * s + 1) begin
            check("idle_en", bram_en, 0);
            check("idle_we", bram_we, 0);
            check("idle_wdata", bram_wdata, 0);
         end else begin
            p = (k - 1) % 5;
            n = (k - 1) / 5;
            check("en", bram_en, 32'(p != 2));
            check("we", bram_we, 32'(p >= 3));
            if (p != 2) check("addr", bram_addr, (p == 0 || p == 3) ? pa[n] : pb[n]);
            if (p == 3) check("wdata_a", bram_wdata, cur[pb[n]]);
            if (p == 4) begin
               check("wdata_b", bram_wdata, cur[pa[n]]);
               t = cur[pa[n]];
               cur[pa[n]] = cur[pb[n]];
               cur[pb[n]] = DW'(t);
            end
         end
      end
   end

   function automatic logic [DW-1:0] pattern(input int pat, input int a);
      case (pat)
         0:       return DW'(a % 16);
         1:       return DW'(a * 7 + 3);
         default: return DW'((a / 16 + 1) * 10 + a % 16);
      endcase
   endfunction

   task automatic preload(input int pat);
      for (int a = 0; a < NW; a++) begin
         @(negedge clk);
         pl_en = 1'b1;
         pl_addr = AW'(a);
         pl_data = pattern(pat, a);
         golden[a] = pl_data;
      end
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic image_check(input string name);
      int bad = 0;
      for (int a = 0; a < NW; a++)
         if (mem[a] !== golden[a]) bad++;
      check(name, bad, 0);
   endtask

   task automatic flip(input int fx, input int fy, input int fw, input int fh, input int fv,
                       input int restart_at, input int reset_at, input int exp_done);
      int s = 0;
      int done_cyc = -1;
      int busy_cnt = 0;
      logic [DW-1:0] t;
      if (fv == 0) begin
         for (int j = 0; j < fh; j++)
            for (int i = 0; i < fw / 2; i++) begin
               cfg_pa[s] = ((fy + j) * ST + fx + i) % NW;
               cfg_pb[s] = ((fy + j) * ST + fx + fw - 1 - i) % NW;
               s++;
            end
      end else begin
         for (int j = 0; j < fh / 2; j++)
            for (int i = 0; i < fw; i++) begin
               cfg_pa[s] = ((fy + j) * ST + fx + i) % NW;
               cfg_pb[s] = ((fy + fh - 1 - j) * ST + fx + i) % NW;
               s++;
            end
      end
      cfg_s = s;
      img_start = golden;
      if (reset_at < 0)
         for (int q = 0; q < s; q++) begin
            t = golden[cfg_pa[q]];
            golden[cfg_pa[q]] = golden[cfg_pb[q]];
            golden[cfg_pb[q]] = t;
         end

      @(negedge clk);
      x0 = CW'(fx); y0 = CW'(fy); w = CW'(fw); h = CW'(fh);
`ifdef FLIP_VERT_EN
      vflip = (fv != 0);
`endif
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x0 = ~x0; y0 = ~y0; w = ~w; h = ~h;
`ifdef FLIP_VERT_EN
      vflip = ~vflip;
`endif
      for (int c = 1; c <= 400; c++) begin
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin
            done_cyc = c;
            break;
         end
         if (reset_at >= 0 && c == reset_at + 1) begin
            check("abort_busy", busy, 0);
            reset = 1'b0;
            break;
         end
         start = (c == restart_at);
         if (c == reset_at) reset = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      if (reset_at < 0) begin
         check("done_cycle", done_cyc, exp_done);
         check("busy_cycles", busy_cnt, exp_done);
      end
   endtask

   initial begin : stim
      int w0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_en", bram_en, 0);
      check("rst_we", bram_we, 0);
      check("rst_addr", bram_addr, 0);
      check("rst_wdata", bram_wdata, 0);

      // Row 0 holds 0..15; reverse the first four words
      preload(0);
      flip(0, 0, 4, 1, 0, -1, -1, 11);
      check("r31_a0", mem[0], 3);
      check("r31_a1", mem[1], 2);
      check("r31_a2", mem[2], 1);
      check("r31_a3", mem[3], 0);
      check("r31_a4", mem[4], 4);
      check("r31_a15", mem[15], 15);
      image_check("r31_image");

      // Odd-width flip twice restores the region; centre column untouched
      preload(1);
      flip(2, 1, 5, 2, 0, -1, -1, 21);
      check("r32_px18", mem[18], pattern(1, 22));
      image_check("r32_image1");
      flip(2, 1, 5, 2, 0, -1, -1, 21);
      image_check("r32_image2");
      check("r32_restored", mem[18], pattern(1, 18));
      check("r32_centre_writes", centre_wr, 0);

      // Degenerate width: no writes, done one cycle after start
      w0 = wr_cnt;
      flip(0, 0, 1, 3, 0, -1, -1, 1);
      check("r33_writes", wr_cnt - w0, 0);
      flip(3, 3, 6, 0, 0, -1, -1, 1);
      check("h0_writes", wr_cnt - w0, 0);

      // Second start during the op is ignored
      preload(0);
      flip(0, 0, 4, 1, 0, 4, -1, 11);
      check("r34_a0", mem[0], 3);
      check("r34_a1", mem[1], 2);
      check("r34_a3", mem[3], 0);
      image_check("r34_image");

      // Reset during WR_A of the second swap
      preload(0);
      flip(0, 0, 4, 1, 0, -1, 9, -1);
      repeat (3) @(negedge clk);
      check("r35_a0", mem[0], 3);
      check("r35_a1", mem[1], 1);
      check("r35_a2", mem[2], 2);
      check("r35_a3", mem[3], 0);

      // Rectangle wrapping past the end of the address space
      preload(1);
      flip(12, 15, 8, 3, 0, -1, -1, 61);
      image_check("wrap_image");
      check("wrap_a0", mem[0], pattern(1, 255));

`ifdef FLIP_VERT_EN
      preload(2);
      flip(0, 0, 2, 3, 1, -1, -1, 11);
      check("r36_row0", mem[0], 30);
      check("r36_row1", mem[16], 20);
      check("r36_row2", mem[32], 10);
      image_check("r36_image");
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bram_flip_sequencer.md
BRAM_FLIP_SEQUENCER -- requirements
Module: bram_flip_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 4, pixel/word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, BRAM address width.
REQ-003 SHALL have parameter COORD_W, default 4, width of each rectangle coordinate/size field.
REQ-004 SHALL have parameter STRIDE, default 16, words per image row; address = y*STRIDE + x.
REQ-005 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  request pulse, sampled only in IDLE.
REQ-008 SHALL have ports x0, y0, w, h  in  COORD_W each  rectangle origin and size, latched on accepted start.
REQ-009 SHALL have port busy  out  1  high in every state except IDLE.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports bram_en  out  1, bram_we  out  1, bram_addr  out  ADDR_W, bram_wdata  out  DATA_W  single-port BRAM master.
REQ-012 SHALL have port bram_rdata  in  DATA_W  read data, valid one cycle after an enabled read.

Function
REQ-013 SHALL implement states IDLE, RD_A, RD_B, CAP_B, WR_A, WR_B, DONE.
REQ-014 IDLE with start=1 SHALL latch x0,y0,w,h and move to RD_A, or directly to DONE when the swap count is zero.
REQ-015 Horizontal mode SHALL swap pixel (x0+i, y0+j) with (x0+w-1-i, y0+j) for i in 0..floor(w/2)-1 and j in 0..h-1, with i as the inner loop.
REQ-016 Each swap SHALL take exactly 5 cycles: RD_A (en, addr A); RD_B (en, addr B, capture rdata as pixA); CAP_B (capture rdata as pixB); WR_A (en, we, addr A, wdata pixB); WR_B (en, we, addr B, wdata pixA).
REQ-017 WR_B SHALL go to RD_A if swaps remain, else to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Total latency from the accepted start edge to done high SHALL be 5*S+1 cycles, where S is the number of swaps.
REQ-020 A degenerate rectangle (w<2 in horizontal mode, h=0, or h<2 in vertical mode) SHALL produce S=0: no BRAM access, and done one cycle after start.
REQ-021 start while busy, including the DONE cycle, SHALL be ignored without side effects.
REQ-022 Address arithmetic SHALL be computed at ADDR_W+COORD_W bits and truncated to ADDR_W; no bounds checking.
REQ-023 bram_en, bram_we and bram_wdata SHALL be 0 in IDLE and DONE.
REQ-024 x0, y0, w and h changing while busy SHALL NOT affect the operation in progress.

Reset
REQ-025 reset SHALL force IDLE and clear busy, done, bram_en, bram_we, bram_addr, bram_wdata, all counters and capture registers, on the next rising edge.
REQ-026 reset mid-operation SHALL abort immediately with no further BRAM writes and no done pulse; partially swapped data is left as-is.

Configuration
REQ-027 With macro FLIP_VERT_EN defined, SHALL add input port vflip (1 bit, latched with start); vflip=1 swaps (x0+i, y0+j) with (x0+i, y0+h-1-j) for j<floor(h/2), i in 0..w-1, with 5-cycle swaps and the same latency formula.
REQ-028 Without FLIP_VERT_EN, port vflip SHALL be absent and only horizontal mode exists.

Structure
REQ-029 State enum, the swap cycle count constant (5), and the address-compute function SHALL live in package flip_pkg.
REQ-030 One sub-module, flip_addr_gen (loop counters i/j, A/B address generation, last-swap flag), is natural; the FSM and data capture stay in the top module.

Verification
REQ-031 BRAM row 0 preloaded 0..15, start with x0=0,y0=0,w=4,h=1 -> addr0..3 = 3,2,1,0, addr4..15 unchanged, done at cycle 11, busy high for cycles 1..11.
REQ-032 Two back-to-back flips of x0=2,y0=1,w=5,h=2 -> region restored to original; centre pixels (4,1) and (4,2) never written.
REQ-033 w=1,h=3 -> no bram_we ever, done one cycle after start.
REQ-034 start pulsed again at cycle 4 of a w=4,h=1 flip -> ignored, exactly one done, result as in REQ-031.
REQ-035 reset asserted in WR_A of the 2nd swap of a w=4,h=1 flip -> first swap committed (addr0=3, addr3=0), addr1=1 and addr2=2 unchanged, no done, busy=0 next cycle.
REQ-036 (FLIP_VERT_EN) vflip=1, x0=0,y0=0,w=2,h=3, column values 10,20,30 -> rows 0 and 2 exchanged, row 1 unchanged, done at cycle 11.
